uart_rx: RTL and testbench
==========================

# uart_rx

Serial-to-AXI-Stream UART receiver, the receive-side counterpart of the UART transmitter in the same UART block. It oversamples the asynchronous `rx_wire` with the system clock and samples each bit at mid-bit. It checks optional parity and the stop bits, then presents each received word on an AXI-Stream master port. Frame format and parameters match the transmitter: 1 start bit, LSB-first data, optional parity bit, STOP_BIT stop bits.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD_RATE, 9600, line rate in bit/s
- DATA_WIDTH, 8, data bits per frame
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BIT, 1, number of stop bits
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_wire  in  1  serial line, asynchronous to clk; idles high
- m_axis_tdata  out  DATA_WIDTH  received word
- m_axis_tuser  out  2  error flags for the word: [0] parity error, [1] framing error
- m_axis_tvalid  out  1  word available
- m_axis_tready  in  1  downstream accepts
- overrun  out  1  one-cycle pulse when a completed word is dropped

## Operation
- BIT_PERIOD = CLK_FREQ/BAUD_RATE (integer division); HALF = BIT_PERIOD/2.
- baud_cnt width is $clog2(BIT_PERIOD).
- rx_wire passes through a 2-flop synchronizer. Both flops reset to 1.
- A falling edge is detected as previous synced value 1 and current synced value 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge moves the FSM to START with baud_cnt = 0.
  - A line held low, for example after a framing error, does not re-arm the FSM.
- START:
  - At baud_cnt == HALF-1, sample the line.
  - If the sample is 0, go to DATA with baud_cnt = 0.
  - If the sample is 1, treat it as a glitch and return to IDLE with no output.
- DATA:
  - Sample each bit at baud_cnt == BIT_PERIOD-1, which is mid-bit.
  - Shift bits in LSB first.
  - After DATA_WIDTH samples, go to PARITY if PARITY != 0, otherwise go to STOP.
- PARITY:
  - Sample one bit.
  - Expected bit: ^data for even mode, ~^data for odd mode. These are the same conventions as the transmitter.
  - If the sampled bit differs from the expected bit, set the parity error flag.
- STOP:
  - Sample STOP_BIT bits, one per BIT_PERIOD.
  - Any stop-bit sample of 0 sets the framing error flag.
  - After the last stop-bit sample, complete the word and return to IDLE. This happens mid-stop-bit, so a following frame is caught at its start edge.
- Word completion:
  - If m_axis_tvalid == 0 or m_axis_tready == 1: load tdata and tuser and set tvalid.
  - Otherwise, when tvalid == 1 and tready == 0: drop the new word, pulse overrun for one cycle, and keep the held word unchanged.
- Output handshake:
  - tdata, tuser and tvalid stay stable while tvalid && !tready.
  - tvalid clears on the cycle after tvalid && tready, unless a word completes in that same cycle; in that case the new word loads and tvalid stays 1.
- Errored words (parity or framing) are still delivered, with their tuser bits set.

## Timing
- Reset values:
  - m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tvalid = 0, overrun = 0.
  - FSM = IDLE, synchronizer flops = 1, baud_cnt = 0.
- Reset mid-frame aborts the frame with no output. The next falling edge after reset release starts a fresh frame.
- The falling edge on rx_wire is seen on synced rx 2 cycles later; the FSM enters START on the next edge.
- Start-bit sample: HALF cycles after START entry.
- Bit k sample (data bits, then parity, then stop): HALF + (k+1)·BIT_PERIOD cycles after START entry.
- m_axis_tvalid rises 1 cycle after the final stop-bit sample.
- Throughput: back-to-back frames are received at full line rate, provided the sink accepts within one frame time.

## Structure
- Shared package uart_pkg holds:
  - Parity mode constants PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2, also used by the transmitter.
  - The rx_state_t enum: IDLE, START, DATA, PARITY, STOP.
  - The tuser bit indices.
- Sub-module uart_rx_sync: 2-flop synchronizer plus falling-edge detect. It outputs the synced rx and a fall pulse.
- The rest of the block is one module: FSM, baud counter, bit counter, shift register and output holding register.

## Test plan
Bench parameters: CLK_FREQ = 1_000_000, BAUD_RATE = 100_000, giving BIT_PERIOD = 10 and HALF = 5.
- PARITY=0, send 0xA5, tready=1 -> one beat: tdata=0xA5, tuser=2'b00.
- PARITY=2, send 0x03 with parity bit 1 (expected 0) -> tdata=0x03, tuser=2'b01.
- PARITY=0, send 0x55 with the stop bit driven 0, then the line returns high -> tdata=0x55, tuser=2'b10. A later 0x0F frame is received correctly.
- Glitch: rx low for 3 cycles, then high -> no tvalid, FSM back in IDLE.
- tready=0, send 0x11 then 0x22 -> tdata holds 0x11 and overrun pulses once. Then raise tready -> one beat of 0x11, then tvalid=0.
- Assert rst after 4 data bits of 0x99 -> all outputs 0. After release, a full 0x3C frame -> tdata=0x3C, tuser=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - parity mode constants (the PARITY parameter of both directions)
//   - bit positions inside the receiver's m_axis_tuser error field
//   - rx_state_t: receiver FSM encoding (also visible on uart_rx.dbg_state)
//   - cnt_width: counter width helper that never returns zero
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int TUSER_PARITY_ERR = 0;
    localparam int TUSER_FRAME_ERR  = 1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: brings the asynchronous serial line into the clk domain and
// flags the idle-to-start transition.
//   clk, rst  : clock, asynchronous active-high reset
//   rx_wire   : raw serial line (idles high)
//   rx_sync   : line after two flops
//   rx_fall   : one-cycle pulse when rx_sync goes 1 -> 0
// All flops reset to 1 so that reset release on an idle line never looks
// like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_wire,
    output logic rx_sync,
    output logic rx_fall
);

    logic sync_q1;
    logic sync_q2;
    logic sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_q1   <= rx_wire;
            sync_q2   <= sync_q1;
            sync_prev <= sync_q2;
        end
    end

    assign rx_sync = sync_q2;
    // A line that stays low never produces another pulse, so a stuck-low
    // line (e.g. after a framing error) cannot re-arm the receiver.
    assign rx_fall = sync_prev & ~sync_q2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver with an AXI-Stream master output.
// Frame: 1 start bit, DATA_WIDTH data bits LSB first, optional parity bit,
// STOP_BIT stop bits. Each bit is sampled at mid-bit from the synchronised
// line.
//   clk, rst       : clock, asynchronous active-high reset
//   rx_wire        : serial input, idles high
//   m_axis_tdata   : received word
//   m_axis_tuser   : [0] parity error, [1] framing error
//   m_axis_tvalid  : word available
//   m_axis_tready  : sink accepts
//   overrun        : one-cycle pulse when a completed word is dropped
//   dbg_state      : current rx_state_t encoding
//
// Output handshake: a beat transfers on a clock edge where tvalid && tready.
// While tvalid && !tready, tdata/tuser/tvalid are held; a word completing in
// that situation is discarded and reported on overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BIT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_wire,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [1:0]            m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  overrun,
    output logic [2:0]            dbg_state
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int CNT_W      = cnt_width(BIT_PERIOD);
    localparam int BIT_W      = cnt_width((DATA_WIDTH > STOP_BIT) ? DATA_WIDTH : STOP_BIT);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_wire (rx_wire),
        .rx_sync (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [CNT_W-1:0]      baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  perr;
    logic                  ferr;

    logic       half_tick;
    logic       bit_tick;
    logic       last_data;
    logic       last_stop;
    logic       sample_data;
    logic       sample_par;
    logic       sample_stop;
    logic       word_done;
    logic       exp_par;
    logic [1:0] word_tuser;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE: begin
                if (rx_fall) state_nxt = RX_START;
            end
            RX_START: begin
                // A line back high at mid start bit was only a glitch.
                if (half_tick) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (bit_tick && last_data)
                    state_nxt = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (bit_tick) state_nxt = RX_STOP;
            end
            RX_STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch the
                // next start edge.
                if (bit_tick && last_stop) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        half_tick   = (baud_cnt == CNT_W'(HALF - 1));
        bit_tick    = (baud_cnt == CNT_W'(BIT_PERIOD - 1));
        last_data   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
        last_stop   = (bit_cnt == BIT_W'(STOP_BIT - 1));
        sample_data = (state == RX_DATA)   && bit_tick;
        sample_par  = (state == RX_PARITY) && bit_tick;
        sample_stop = (state == RX_STOP)   && bit_tick;
        word_done   = sample_stop && last_stop;
        exp_par     = (PARITY == PARITY_EVEN) ? ^shift_reg : ~^shift_reg;
        word_tuser  = 2'b00;
        word_tuser[TUSER_PARITY_ERR] = perr;
        // The last stop sample is folded in here since ferr only updates
        // on the same edge that loads the word.
        word_tuser[TUSER_FRAME_ERR]  = ferr | ~rx_s;
        dbg_state   = state;
    end

    // Baud counter, bit counter, shift register, error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            if (state == RX_IDLE || state_nxt != state || bit_tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (sample_data || sample_stop) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (sample_data) begin
                shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
            end

            if (state == RX_START && state_nxt == RX_DATA) begin
                perr <= 1'b0;
                ferr <= 1'b0;
            end else begin
                if (sample_par && (rx_s != exp_par)) perr <= 1'b1;
                if (sample_stop && !rx_s)            ferr <= 1'b1;
            end
        end
    end

    // AXI-Stream holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 2'b00;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= word_done && m_axis_tvalid && !m_axis_tready;
            if (word_done && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= shift_reg;
                m_axis_tuser  <= word_tuser;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with BIT_PERIOD = 10, HALF = 5.
// Two receivers share clk/rst: dut_n without parity, dut_p with even parity.
// Each has its own serial line, tready and expected-beat queue; a monitor
// per receiver pops and compares every accepted beat.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BP = 10;

    logic       clk;
    logic       rst;

    logic       rx_n, rx_p;
    logic [7:0] tdata_n, tdata_p;
    logic [1:0] tuser_n, tuser_p;
    logic       tvalid_n, tvalid_p;
    logic       tready_n, tready_p;
    logic       ovr_n, ovr_p;
    logic [2:0] state_n, state_p;

    logic [9:0] exp_n_q[$];
    logic [9:0] exp_p_q[$];

    int n_tests;
    int n_fail;
    int ovr_cnt_n;
    int ovr_cnt_p;

    uart_rx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
        .PARITY(0), .STOP_BIT(1)
    ) dut_n (
        .clk(clk), .rst(rst), .rx_wire(rx_n),
        .m_axis_tdata(tdata_n), .m_axis_tuser(tuser_n),
        .m_axis_tvalid(tvalid_n), .m_axis_tready(tready_n),
        .overrun(ovr_n), .dbg_state(state_n)
    );

    uart_rx #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
        .PARITY(2), .STOP_BIT(1)
    ) dut_p (
        .clk(clk), .rst(rst), .rx_wire(rx_p),
        .m_axis_tdata(tdata_p), .m_axis_tuser(tuser_p),
        .m_axis_tvalid(tvalid_p), .m_axis_tready(tready_p),
        .overrun(ovr_p), .dbg_state(state_p)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not complete within 50000 cycles");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input bit which, input logic v);
        if (which) rx_p = v;
        else       rx_n = v;
    endtask

    task automatic drive_bit(input bit which, input logic v);
        set_rx(which, v);
        repeat (BP) tick();
    endtask

    // Full frame, then one idle bit time with the line high.
    task automatic send_frame(input bit which, input logic [7:0] data,
                              input bit has_par, input logic par_bit,
                              input logic stop_val);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
        if (has_par) drive_bit(which, par_bit);
        drive_bit(which, stop_val);
        drive_bit(which, 1'b1);
    endtask

    task automatic wait_drain(input bit which, input string name);
        int k;
        k = 0;
        while (((which ? exp_p_q.size() : exp_n_q.size()) != 0) && k < 300) begin
            tick();
            k++;
        end
        check(name, 32'(which ? exp_p_q.size() : exp_n_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard monitors ----------------
    initial begin
        logic [9:0] e;
        ovr_cnt_n = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ovr_n) ovr_cnt_n++;
                if (tvalid_n && tready_n) begin
                    if (exp_n_q.size() == 0) begin
                        check("unexpected_beat_n", {22'd0, tuser_n, tdata_n}, 32'h3ff);
                    end else begin
                        e = exp_n_q.pop_front();
                        check("beat_n", {22'd0, tuser_n, tdata_n}, {22'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        logic [9:0] e;
        ovr_cnt_p = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ovr_p) ovr_cnt_p++;
                if (tvalid_p && tready_p) begin
                    if (exp_p_q.size() == 0) begin
                        check("unexpected_beat_p", {22'd0, tuser_p, tdata_p}, 32'h3ff);
                    end else begin
                        e = exp_p_q.pop_front();
                        check("beat_p", {22'd0, tuser_p, tdata_p}, {22'd0, e});
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  ovr_base;
        bit  saw_valid;

        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rx_n     = 1'b1;
        rx_p     = 1'b1;
        tready_n = 1'b1;
        tready_p = 1'b1;
        repeat (3) tick();

        check("rst_tdata",  32'(tdata_n),  32'd0);
        check("rst_tuser",  32'(tuser_n),  32'd0);
        check("rst_tvalid", 32'(tvalid_n), 32'd0);
        check("rst_overrun", 32'(ovr_n),   32'd0);
        check("rst_state",  32'(state_n),  32'(RX_IDLE));
        check("rst_tvalid_p", 32'(tvalid_p), 32'd0);

        rst = 1'b0;
        repeat (5) tick();

        // Plain word, no parity.
        exp_n_q.push_back({2'b00, 8'hA5});
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_drain(1'b0, "drain_a5");

        // Even parity: ^0x03 = 0, so a parity bit of 1 is an error.
        exp_p_q.push_back({2'b01, 8'h03});
        send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
        wait_drain(1'b1, "drain_03");

        // Framing error, then a clean frame after the line recovers.
        exp_n_q.push_back({2'b10, 8'h55});
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        wait_drain(1'b0, "drain_55");
        exp_n_q.push_back({2'b00, 8'h0F});
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        wait_drain(1'b0, "drain_0f");

        // Glitch: 3 cycles low is rejected at the start-bit sample.
        saw_valid = 1'b0;
        rx_n = 1'b0;
        repeat (3) tick();
        rx_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (tvalid_n) saw_valid = 1'b1;
        end
        check("glitch_tvalid", 32'(saw_valid), 32'd0);
        check("glitch_state",  32'(state_n),   32'(RX_IDLE));

        // Overrun: sink stalled, second word dropped.
        tick();
        tready_n = 1'b0;
        ovr_base = ovr_cnt_n;
        exp_n_q.push_back({2'b00, 8'h11});
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        check("hold_tvalid", 32'(tvalid_n), 32'd1);
        check("hold_tdata",  32'(tdata_n),  32'h11);
        check("overrun_pulses", 32'(ovr_cnt_n - ovr_base), 32'd1);
        tready_n = 1'b1;
        wait_drain(1'b0, "drain_11");
        repeat (3) tick();
        check("after_accept_tvalid", 32'(tvalid_n), 32'd0);

        // Reset in the middle of 0x99 (after 4 data bits).
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        set_rx(1'b0, 1'b1);
        repeat (3) tick();
        check("midframe_state", 32'(state_n), 32'(RX_DATA));
        rst = 1'b1;
        #1;
        check("mid_rst_tdata",  32'(tdata_n),  32'd0);
        check("mid_rst_tuser",  32'(tuser_n),  32'd0);
        check("mid_rst_tvalid", 32'(tvalid_n), 32'd0);
        check("mid_rst_state",  32'(state_n),  32'(RX_IDLE));
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        exp_n_q.push_back({2'b00, 8'h3C});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_drain(1'b0, "drain_3c");

        repeat (20) tick();
        check("final_q_n", 32'(exp_n_q.size()), 32'd0);
        check("final_q_p", 32'(exp_p_q.size()), 32'd0);
        check("final_ovr_p", 32'(ovr_cnt_p), 32'd0);
        check("final_tvalid_n", 32'(tvalid_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
